// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the default writeback payload layout.
package mips_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned REG_ZERO   = 0;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] result;
      logic [DEF_ADDR_W-1:0] waddr;
      logic                  we;
      logic                  hilo_we;
      logic [DEF_DATA_W-1:0] hi;
      logic [DEF_DATA_W-1:0] lo;
   } wb_payload_t;

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush; in_ready depends only on held state.
module skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid_q, main_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_fire, out_fire;

   assign in_ready  = ~skid_valid_q & ~rst;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_valid_q & out_ready;
   assign out_valid = main_valid_q;
   assign out_data  = main_q;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (~main_valid_q | out_fire) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            main_d       = in_data;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         // Main is stalled: park the new entry so the producer is not stalled this cycle.
         skid_d       = in_data;
         skid_valid_d = 1'b1;
      end
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
      end
   end

endmodule

// File: rtl/pipe_wb_reg.sv
// MEM->WB pipeline register: skid-buffered handshake, zero-register write suppression,
// bubble gating of write enables, optional HI/LO channel and saturating stall counter.
module pipe_wb_reg
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W        = DEF_DATA_W,
   parameter int unsigned ADDR_W        = DEF_ADDR_W,
   parameter bit          HILO_EN       = 1'b1,
   parameter bit          ZERO_SUPPRESS = 1'b1,
   parameter int unsigned CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] result_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic              we_i,
   input  logic              hilo_we_i,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic              we_o,
   output logic              hilo_we_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [ADDR_W-1:0] waddr;
      logic              we;
      logic              hilo_we;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } pay_t;

   localparam int unsigned PAY_W = $bits(pay_t);

   pay_t             pay_in, pay_out;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Capture-side shaping: zero-register suppression and HI/LO tie-off.
   always_comb begin
      pay_in.result  = result_i;
      pay_in.waddr   = waddr_i;
      pay_in.we      = we_i;
      pay_in.hilo_we = 1'b0;
      pay_in.hi      = '0;
      pay_in.lo      = '0;
      if (ZERO_SUPPRESS && (waddr_i == ADDR_W'(REG_ZERO))) pay_in.we = 1'b0;
      if (HILO_EN) begin
         pay_in.hilo_we = hilo_we_i;
         pay_in.hi      = hi_i;
         pay_in.lo      = lo_i;
      end
   end

   skid_buf #(.W(PAY_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (pay_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (pay_out)
   );

   assign result_o  = pay_out.result;
   assign waddr_o   = pay_out.waddr;
   assign we_o      = pay_out.we & out_valid;
   assign hilo_we_o = pay_out.hilo_we & out_valid;
   assign hi_o      = pay_out.hi;
   assign lo_o      = pay_out.lo;
   assign stall_cnt = stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

endmodule

// File: tb/tb_pipe_wb_reg.sv
// Directed bench for pipe_wb_reg: default build plus a ZERO_SUPPRESS=0/CNT_W=2/HILO_EN=0 build.
module tb_pipe_wb_reg;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] result_i, hi_i, lo_i;
   logic [4:0]  waddr_i;
   logic        we_i, hilo_we_i;

   logic        in_ready, out_valid, we_o, hilo_we_o;
   logic [31:0] result_o, hi_o, lo_o;
   logic [4:0]  waddr_o;
   logic [15:0] stall_cnt;

   logic        in_ready2, out_valid2, we_o2, hilo_we_o2;
   logic [31:0] result_o2, hi_o2, lo_o2;
   logic [4:0]  waddr_o2;
   logic [1:0]  stall_cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_wb_reg dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .result_i(result_i), .waddr_i(waddr_i), .we_i(we_i), .hilo_we_i(hilo_we_i),
      .hi_i(hi_i), .lo_i(lo_i), .out_valid(out_valid), .out_ready(out_ready),
      .result_o(result_o), .waddr_o(waddr_o), .we_o(we_o), .hilo_we_o(hilo_we_o),
      .hi_o(hi_o), .lo_o(lo_o), .stall_cnt(stall_cnt)
   );

   pipe_wb_reg #(.HILO_EN(1'b0), .ZERO_SUPPRESS(1'b0), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
      .result_i(result_i), .waddr_i(waddr_i), .we_i(we_i), .hilo_we_i(hilo_we_i),
      .hi_i(hi_i), .lo_i(lo_i), .out_valid(out_valid2), .out_ready(out_ready),
      .result_o(result_o2), .waddr_o(waddr_o2), .we_o(we_o2), .hilo_we_o(hilo_we_o2),
      .hi_o(hi_o2), .lo_o(lo_o2), .stall_cnt(stall_cnt2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] a,
                        input logic we, input logic hwe, input logic [31:0] hi, input logic [31:0] lo);
      in_valid  = v;
      result_i  = res;
      waddr_i   = a;
      we_i      = we;
      hilo_we_i = hwe;
      hi_i      = hi;
      lo_i      = lo;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(1'b1, 32'h99, 5'd7, 1'b1, 1'b1, 32'h5, 32'h6);

      // Reset held two cycles with a valid input present
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_in_ready", in_ready, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_we_o", we_o, 0);
         check("rst_stall_cnt", stall_cnt, 0);
      end
      rst = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("post_rst_in_ready", in_ready, 1);

      // Streaming at full rate
      drive(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      check("s1_valid", out_valid, 1);
      check("s1_result", result_o, 32'h11);
      check("s1_waddr", waddr_o, 1);
      check("s1_we", we_o, 1);
      drive(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      check("s2_result", result_o, 32'h22);
      check("s2_waddr", waddr_o, 2);
      check("s2_we", we_o, 1);
      drive(1'b1, 32'h33, 5'd3, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      check("s3_result", result_o, 32'h33);
      check("s3_we", we_o, 1);
      in_valid = 1'b0;
      tick();
      check("s_drain_valid", out_valid, 0);
      check("s_drain_we", we_o, 0);
      check("s_stall_cnt", stall_cnt, 0);

      // Stall with skid capture, then release
      out_ready = 1'b0;
      drive(1'b1, 32'hA, 5'd4, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      check("k1_result", result_o, 32'hA);
      check("k1_in_ready", in_ready, 1);
      check("k1_stall_cnt", stall_cnt, 0);
      drive(1'b1, 32'hB, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      check("k2_result_held", result_o, 32'hA);
      check("k2_in_ready", in_ready, 0);
      check("k2_stall_cnt", stall_cnt, 1);
      in_valid = 1'b0;
      tick();
      check("k3_result_held", result_o, 32'hA);
      check("k3_stall_cnt", stall_cnt, 2);
      out_ready = 1'b1;
      tick();
      check("k4_result", result_o, 32'hB);
      check("k4_waddr", waddr_o, 5);
      check("k4_valid", out_valid, 1);
      check("k4_in_ready", in_ready, 1);
      check("k4_stall_cnt", stall_cnt, 2);
      tick();
      check("k5_valid", out_valid, 0);

      // Flush with main and skid both occupied and 0xC presented
      out_ready = 1'b0;
      drive(1'b1, 32'hA, 5'd4, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      drive(1'b1, 32'hB, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      check("f_pre_in_ready", in_ready, 0);
      check("f_pre_result", result_o, 32'hA);
      flush = 1'b1;
      drive(1'b1, 32'hC, 5'd6, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      check("f_valid", out_valid, 0);
      check("f_we", we_o, 0);
      check("f_in_ready", in_ready, 1);
      check("f_stall_cnt", stall_cnt, 4);
      check("f_stall_cnt_sat", stall_cnt2, 3);
      // Flush while empty: an accepted entry is still dropped
      drive(1'b1, 32'hE, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      check("f2_valid", out_valid, 0);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("f3_valid", out_valid, 0);
      check("f3_we", we_o, 0);

      // Zero-register write suppression
      drive(1'b1, 32'hDEAD, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      check("z_valid", out_valid, 1);
      check("z_result", result_o, 32'hDEAD);
      check("z_we_suppressed", we_o, 0);
      check("z_we_nosuppress", we_o2, 1);

      // HI/LO channel and held payload during a long stall
      drive(1'b1, 32'h55, 5'd6, 1'b1, 1'b1, 32'h1, 32'h2);
      tick();
      check("h_hilo_we", hilo_we_o, 1);
      check("h_hi", hi_o, 1);
      check("h_lo", lo_o, 2);
      check("h_hilo_we_off", hilo_we_o2, 0);
      check("h_hi_off", hi_o2, 0);
      check("h_lo_off", lo_o2, 0);
      in_valid = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("h_held_result", result_o, 32'h55);
      check("h_held_hilo_we", hilo_we_o, 1);
      check("h_stall_cnt", stall_cnt, 10);
      check("h_stall_cnt_sat", stall_cnt2, 3);
      out_ready = 1'b1;
      tick();
      check("b_valid", out_valid, 0);
      check("b_we", we_o, 0);
      check("b_hilo_we", hilo_we_o, 0);
      check("b_stall_cnt", stall_cnt, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_wb_reg.md
Name: pipe_wb_reg

Overview:
Parametrised MEM->WB pipeline register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and optional HI/LO writeback channel. It replaces the fixed, always-advancing MEM/WB latch so the WB side can stall (e.g. register-file port conflict) without dropping or duplicating instructions. It sits between the MEM stage and the register file / HI-LO unit.

Parameters:
DATA_W, 32, width of the result and HI/LO payloads
ADDR_W, 5, register-file address width
HILO_EN, 1, 1 = HI/LO channel present; 0 = HI/LO outputs tied to 0
ZERO_SUPPRESS, 1, 1 = a write to address 0 has its write enable forced to 0 at capture
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all held entries (exception/branch recovery)
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  block accepts an entry this cycle
result_i  in  DATA_W  ALU/load result
waddr_i  in  ADDR_W  destination register
we_i  in  1  register write enable
hilo_we_i  in  1  HI/LO write enable
hi_i  in  DATA_W  HI value
lo_i  in  DATA_W  LO value
out_valid  out  1  WB entry present
out_ready  in  1  WB consumes the entry this cycle
result_o  out  DATA_W  held result
waddr_o  out  ADDR_W  held destination
we_o  out  1  we of held entry AND out_valid
hilo_we_o  out  1  hilo_we of held entry AND out_valid (0 if HILO_EN=0)
hi_o  out  DATA_W  held HI
lo_o  out  DATA_W  held LO
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset: rst, clk as decided above. All valid bits, payload registers and stall_cnt go to 0 on the reset edge. in_ready = ~skid_valid & ~rst, so it is 0 while rst=1 and 1 on the first cycle after reset.
- Storage: main entry (drives outputs) plus skid entry. in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Main update: when main is empty or out_fire:
  - if skid is valid, main <- skid and skid is emptied;
  - else if in_fire, main <- input;
  - else main becomes empty.
- Skid capture: when main is held (out_valid & ~out_ready) and in_fire, skid <- input.
- in_ready is registered-derived from skid_valid only. It has no combinational path from out_ready.
- Latency: 1 cycle from in_fire to out_valid with an empty pipe. Throughput is 1 entry/cycle when out_ready=1.
- Ordering is strict FIFO. No entry is lost or duplicated under any valid/ready pattern.
- Payload registers load only on capture; they hold their value while stalled.
- ZERO_SUPPRESS=1: the captured we = we_i & (waddr_i != 0).
- flush (priority: rst > flush > normal):
  - next cycle both valid bits are 0;
  - an entry presented in the flush cycle is dropped even if in_fire;
  - payload may retain stale data, but we_o and hilo_we_o are 0 because they are gated by out_valid.
- stall_cnt increments when out_valid & ~out_ready. It saturates at all-ones and is cleared only by rst. flush does not clear it.
- Bubble rule: we_o = hilo_we_o = 0 whenever out_valid = 0.

Decomposition:
- Shared package (mips_pkg): DATA_W and ADDR_W defaults, REG_ZERO address constant, wb_payload_t struct {result, waddr, we, hilo_we, hi, lo}.
- One natural sub-module: skid_buf, a generic 2-entry valid/ready skid buffer over a packed payload with a flush input. pipe_wb_reg instantiates it and adds the zero-suppress, enable gating, HILO_EN tie-off and stall counter.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, we_o=0, stall_cnt=0. First cycle after reset: in_ready=1.
- Streaming: out_ready=1, send results 0x11, 0x22, 0x33 to waddr 1, 2, 3 on consecutive cycles -> same values on out in order, each 1 cycle later, we_o=1 for each.
- Stall/skid: out_ready=0; send 0xA then 0xB -> out holds 0xA, in_ready falls to 0 after the second accept, stall_cnt counts up. Then out_ready=1 -> 0xA then 0xB, with no loss or duplication.
- Flush: main=0xA and skid=0xB valid; assert flush with in_valid=1 carrying 0xC -> next cycle out_valid=0, we_o=0, in_ready=1, and 0xC never appears.
- Zero suppression: waddr_i=0, we_i=1, result 0xDEAD -> out_valid=1, we_o=0. With ZERO_SUPPRESS=0 -> we_o=1.
- HILO and saturation: with HILO_EN=1, send hi=0x1, lo=0x2, hilo_we=1 -> hilo_we_o=1 with both values. With CNT_W=2, stall 6 cycles -> stall_cnt=3.
